// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-slot TDM receive path.
package tdm_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;
endpackage

// File: rtl/tdm_demux1_4_if.sv
// Serial-in / parallel-out bundle between the TDM link and the demux.
interface tdm_demux1_4_if #(parameter int W = 1);
   import tdm_pkg::*;

   logic [W-1:0]           din;
   logic                   din_valid;
   logic                   sync;
   logic [NUM_SLOTS*W-1:0] dout;
   logic [SLOT_W-1:0]      slot;
   logic                   frame_valid;
   logic                   sync_err;
   logic                   locked;

   modport master (output din, din_valid, sync,
                   input  dout, slot, frame_valid, sync_err, locked);
   modport slave  (input  din, din_valid, sync,
                   output dout, slot, frame_valid, sync_err, locked);
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot index counter; clear beats load-to-1, which beats advance.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  logic              load1,
   input  logic              clear,
   output logic [SLOT_W-1:0] slot,
   output logic              wrap
);
   logic [SLOT_W-1:0] slot_q, slot_d;

   always_comb begin
      slot_d = slot_q;
      wrap   = 1'b0;
      if (clear) begin
         slot_d = '0;
      end else if (load1) begin
         slot_d = SLOT_W'(1);
      end else if (advance) begin
         slot_d = slot_q + SLOT_W'(1);
         wrap   = (slot_q == SLOT_W'(NUM_SLOTS - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) slot_q <= '0;
      else        slot_q <= slot_d;
   end

   assign slot = slot_q;
endmodule

// File: rtl/tdm_demux1_4.sv
// TDM 1:4 demux: locks to slot-0 sync, collects slots 0..2 in a shadow
// register and publishes all four lanes together when slot 3 arrives.
module tdm_demux1_4
   import tdm_pkg::*;
#(
   parameter int W          = 1,
   parameter int MISS_LIMIT = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   tdm_demux1_4_if.slave  bus
);
   localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

   state_e                              state_q, state_d;
   logic [MISS_W-1:0]                   miss_q, miss_d;
   logic [NUM_SLOTS-2:0][W-1:0]         shadow_q, shadow_d;
   logic [NUM_SLOTS*W-1:0]              dout_q, dout_d;
   logic                                fv_q, fv_d;
   logic                                serr_q, serr_d;

   logic              adv, load1, clr, wrap;
   logic [SLOT_W-1:0] slot;

   tdm_slot_ctr u_slot_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (adv),
      .load1   (load1),
      .clear   (clr),
      .slot    (slot),
      .wrap    (wrap)
   );

   always_comb begin
      state_d  = state_q;
      miss_d   = miss_q;
      shadow_d = shadow_q;
      serr_d   = 1'b0;
      adv      = 1'b0;
      load1    = 1'b0;
      clr      = 1'b0;
      if (bus.din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (bus.sync) begin
                  shadow_d[0] = bus.din;
                  load1       = 1'b1;
                  miss_d      = '0;
                  state_d     = LOCKED;
               end
            end
            LOCKED: begin
               if (bus.sync) begin
                  // A sync mid-frame restarts the frame at this sample.
                  serr_d      = (slot != '0);
                  shadow_d[0] = bus.din;
                  load1       = 1'b1;
                  miss_d      = '0;
               end else if (slot == '0) begin
                  if (int'(miss_q) + 1 < MISS_LIMIT) begin
                     shadow_d[0] = bus.din;
                     adv         = 1'b1;
                     miss_d      = miss_q + MISS_W'(1);
                  end else begin
                     clr     = 1'b1;
                     miss_d  = '0;
                     state_d = HUNT;
                  end
               end else begin
                  case (slot)
                     2'd1:    shadow_d[1] = bus.din;
                     2'd2:    shadow_d[2] = bus.din;
                     default: ;
                  endcase
                  adv = 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Publication keys off the counter's wrap so dout only moves on a full frame.
   always_comb begin
      dout_d = dout_q;
      fv_d   = 1'b0;
      if (wrap) begin
         dout_d = {bus.din, shadow_q};
         fv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         miss_q   <= '0;
         shadow_q <= '0;
         dout_q   <= '0;
         fv_q     <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         miss_q   <= miss_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         fv_q     <= fv_d;
         serr_q   <= serr_d;
      end
   end

   assign bus.dout        = dout_q;
   assign bus.slot        = slot;
   assign bus.frame_valid = fv_q;
   assign bus.sync_err    = serr_q;
   assign bus.locked      = (state_q == LOCKED);
endmodule
